cpu_eth_tx: RTL
===============

# cpu_eth_tx

CPU-driven Ethernet frame transmitter on the housekeeping clock. It is the transmit counterpart to the Ethernet receive path that feeds the CPU. The CPU writes a frame payload byte by byte into an internal buffer and commits it with `send`. The block then emits preamble, SFD, payload, zero padding to minimum length and CRC-32 FCS as a byte stream with a valid/ready handshake. That stream feeds the PHY transmit arbitration alongside the sample streamer.

## Interface

**Parameters**
- `ADDR_W`, default 9: buffer address width; capacity is 2^ADDR_W bytes (512).
- `MIN_LEN`, default 60: minimum payload+pad bytes, excluding FCS.
- `IFG_CYCLES`, default 12: idle cycles after the last FCS transfer before `busy` drops.

**Ports**
- `clk_cpu`  in  1  sole clock.
- `clk_cpu_reset`  in  1  synchronous, active-high reset.
- `wr_data`  in  8  payload byte from the CPU.
- `wr_en`  in  1  appends `wr_data` at the write pointer.
- `send`  in  1  single-cycle pulse that commits the buffered frame.
- `busy`  out  1  high from an accepted `send` until the IFG completes.
- `frame_len`  out  ADDR_W+1  number of bytes currently buffered.
- `overflow`  out  1  sticky; set when a write was dropped because the buffer was full.
- `tx_data`  out  8  outgoing byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  downstream accepts; a transfer occurs when `tx_valid && tx_ready`.
- `tx_last`  out  1  qualifies the final FCS byte.

## Operation

**Buffer**
- Single-port-write, synchronous-read RAM of 2^ADDR_W x 8.
- When not busy, `wr_en` writes at `frame_len` and increments it.
- When `frame_len` is 2^ADDR_W, `wr_en` is dropped and sets `overflow`.

**Commit**
- `send` while not busy and with `frame_len` > 0 is accepted.
- `send` while busy, or with `frame_len` = 0, is ignored.
- `wr_en` and `send` in the same cycle: the byte is written first and is included in the frame.
- `wr_en` while busy is ignored and sets `overflow`.
- An accepted `send` clears `overflow`.

**State machine**
- IDLE: on an accepted `send`, go to PRE.
- PRE: 7 transfers of 0x55, then SFD.
- SFD: 1 transfer of 0xD5, then DATA.
- DATA: buffer bytes in write order, `frame_len` transfers. If `frame_len` < MIN_LEN go to PAD, otherwise go to FCS.
- PAD: 0x00 transfers until payload+pad = MIN_LEN, then FCS.
- FCS: 4 transfers; `tx_last` is asserted on the 4th.
- IFG: `tx_valid`=0 for IFG_CYCLES cycles, then go to IDLE. On that transition `busy` drops and `frame_len` returns to 0.

**CRC**
- IEEE 802.3 CRC-32, reflected form, polynomial 0x04C11DB7, initial value 0xFFFFFFFF.
- Computed over DATA and PAD bytes only.
- FCS = bitwise complement of the CRC register, sent least-significant byte first.
- The CRC advances only on a handshake.

**Overflowed frame**
- Transmits exactly 2^ADDR_W payload bytes.

## Timing

**Reset values**
- `busy`=0, `frame_len`=0, `overflow`=0, `tx_valid`=0, `tx_last`=0, `tx_data`=0x00.
- State is IDLE and the CRC register is 0xFFFFFFFF.

**Latency**
- An accepted `send` in cycle N gives `tx_valid`=1 with `tx_data`=0x55 in cycle N+1.
- `busy`=1 from cycle N+1.

**Handshake**
- While `tx_valid`=1 and `tx_ready`=0, `tx_data`, `tx_valid` and `tx_last` hold stable.
- `tx_valid` never drops between the first preamble byte and `tx_last`.
- With `tx_ready` held at 1, one byte transfers per cycle with no bubbles, including across the SFD-to-DATA, DATA-to-PAD and DATA/PAD-to-FCS boundaries.
- Buffer reads are prefetched to hide the 1-cycle RAM latency.

**IFG and throughput**
- The cycle after the `tx_last` handshake has `tx_valid`=0.
- `busy` drops exactly IFG_CYCLES+1 cycles after the `tx_last` handshake.
- A frame occupies 8 + max(`frame_len`, MIN_LEN) + 4 transfers.

**Reset mid-frame**
- In the next cycle all outputs take their reset values.
- The frame is truncated with no `tx_last`; the downstream discards it by its bad FCS.

## Test plan

- Write 60 bytes 0x00..0x3B, `send`, `tx_ready`=1 → 72 contiguous transfers: 7×0x55, 0xD5, 0x00..0x3B, 4 FCS bytes. FCS matches the software model, CRC over payload+FCS yields residue 0xDEBB20E3, and `tx_last` is on transfer 72.
- Write the single byte 0xAB, `send` → 0xAB, then 59×0x00, then FCS; 72 transfers total.
- 100-byte frame with `tx_ready` low for 5 cycles mid-DATA and randomly toggled elsewhere → outputs stable while stalled; the received byte sequence is identical to the `tx_ready`=1 run.
- Write 520 bytes → `overflow`=1 and `frame_len`=512. `send` → `overflow`=0 and 524 transfers.
- While busy, pulse `wr_en`/`send` → ignored, `frame_len` unchanged, `overflow`=1. `busy` falls exactly IFG_CYCLES+1 cycles after `tx_last`, and `frame_len`=0 afterwards.
- Assert `clk_cpu_reset` during PAD → next cycle `tx_valid`=0, `busy`=0, `frame_len`=0. A following 1-byte frame transmits correctly with a correct FCS.

Source files
------------

// File: rtl/cpu_eth_tx.sv
// CPU-loaded Ethernet frame transmitter: buffers a payload, then streams preamble, SFD,
// payload, zero pad and CRC-32 FCS over a valid/ready byte interface.
module cpu_eth_tx #(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned MIN_LEN    = 60,
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic              clk_cpu,
    input  logic              clk_cpu_reset,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    input  logic              send,
    output logic              busy,
    output logic [ADDR_W:0]   frame_len,
    output logic              overflow,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CW    = ADDR_W + 1;
    localparam logic [CW-1:0] FullLen = CW'(DEPTH);
    localparam logic [CW-1:0] MinLen  = CW'(MIN_LEN);
    localparam logic [CW-1:0] IfgLast = CW'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StPre, StSfd, StData, StPad, StFcs, StIfg} state_e;

    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        ram_q;
    logic [ADDR_W-1:0] rd_ptr_q, rd_addr;
    state_e            state_q;
    logic [CW-1:0]     cnt_q, frame_len_q;
    logic              busy_q, overflow_q, tx_valid_q, tx_last_q;
    logic [7:0]        tx_data_q, fcs_nxt;
    logic [31:0]       crc_q, crc_nxt;
    logic              hs, wr_ok, accept, data_end, consume;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        hs       = tx_valid_q && tx_ready;
        wr_ok    = wr_en && !busy_q && (frame_len_q != FullLen);
        accept   = send && !busy_q && ((frame_len_q != '0) || wr_ok);
        data_end = (cnt_q == frame_len_q - CW'(1));
        // Advance the read pointer whenever ram_q is loaded so it always holds mem[rd_ptr_q]
        consume  = hs && ((state_q == StSfd) || ((state_q == StData) && !data_end));
        rd_addr  = consume ? rd_ptr_q + 1'b1 : rd_ptr_q;
        crc_nxt  = crc_byte(crc_q, tx_data_q);
        case (cnt_q[1:0])
            2'd0:    fcs_nxt = ~crc_q[15:8];
            2'd1:    fcs_nxt = ~crc_q[23:16];
            2'd2:    fcs_nxt = ~crc_q[31:24];
            default: fcs_nxt = ~crc_q[7:0];
        endcase
    end

    always_ff @(posedge clk_cpu) begin
        if (wr_ok) begin
            mem_q[frame_len_q[ADDR_W-1:0]] <= wr_data;
        end
        ram_q <= mem_q[rd_addr];
    end

    always_ff @(posedge clk_cpu) begin
        if (clk_cpu_reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            frame_len_q <= '0;
            rd_ptr_q    <= '0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            tx_data_q   <= 8'h00;
            crc_q       <= 32'hFFFFFFFF;
        end else begin
            rd_ptr_q <= rd_addr;
            if (wr_ok) begin
                frame_len_q <= frame_len_q + CW'(1);
            end
            if (wr_en && !wr_ok) begin
                overflow_q <= 1'b1;
            end
            if (accept) begin
                overflow_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q    <= StPre;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= 8'h55;
                        crc_q      <= 32'hFFFFFFFF;
                    end
                end
                StPre: begin
                    if (hs) begin
                        if (cnt_q == CW'(6)) begin
                            state_q   <= StSfd;
                            tx_data_q <= 8'hD5;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                StSfd: begin
                    if (hs) begin
                        state_q   <= StData;
                        tx_data_q <= ram_q;
                        cnt_q     <= '0;
                    end
                end
                StData: begin
                    if (hs) begin
                        crc_q <= crc_nxt;
                        if (!data_end) begin
                            tx_data_q <= ram_q;
                            cnt_q     <= cnt_q + CW'(1);
                        end else if (frame_len_q < MinLen) begin
                            state_q   <= StPad;
                            tx_data_q <= 8'h00;
                            cnt_q     <= cnt_q + CW'(1);
                        end else begin
                            state_q   <= StFcs;
                            tx_data_q <= ~crc_nxt[7:0];
                            cnt_q     <= '0;
                        end
                    end
                end
                StPad: begin
                    // cnt_q counts payload+pad bytes, continuing from the data phase
                    if (hs) begin
                        crc_q <= crc_nxt;
                        if (cnt_q == MinLen - CW'(1)) begin
                            state_q   <= StFcs;
                            tx_data_q <= ~crc_nxt[7:0];
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                StFcs: begin
                    if (hs) begin
                        if (cnt_q == CW'(3)) begin
                            state_q    <= StIfg;
                            tx_valid_q <= 1'b0;
                            tx_last_q  <= 1'b0;
                            tx_data_q  <= 8'h00;
                            cnt_q      <= '0;
                        end else begin
                            tx_data_q <= fcs_nxt;
                            tx_last_q <= (cnt_q == CW'(2));
                            cnt_q     <= cnt_q + CW'(1);
                        end
                    end
                end
                StIfg: begin
                    if (cnt_q == IfgLast) begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        frame_len_q <= '0;
                        rd_ptr_q    <= '0;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = busy_q;
    assign frame_len = frame_len_q;
    assign overflow  = overflow_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign tx_last   = tx_last_q;

endmodule
